// File: rtl/sram_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_ctrl
// Description : Round-robin arbiter for two 32-bit ports sharing one 16-bit
//               asynchronous SRAM, split into low/high halfword phases.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_p0_valid,
    input  logic              i_p0_we,
    input  logic [31:0]       i_p0_addr,
    input  logic [3:0]        i_p0_bmask,
    input  logic [31:0]       i_p0_wdata,
    output logic              o_p0_ready,
    output logic              o_p0_rvalid,
    output logic [31:0]       o_p0_rdata,

    input  logic              i_p1_valid,
    input  logic              i_p1_we,
    input  logic [31:0]       i_p1_addr,
    input  logic [3:0]        i_p1_bmask,
    input  logic [31:0]       i_p1_wdata,
    output logic              o_p1_ready,
    output logic              o_p1_rvalid,
    output logic [31:0]       o_p1_rdata,

    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_dq_o,
    output logic              o_sram_dq_oe,
    input  logic [15:0]       i_sram_dq_i,
    output logic              o_sram_ce_n,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    localparam int                 c_cnt_w    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_next;
    logic                r_last_grant;
    logic                r_gnt;
    logic                r_we;
    logic [ADDR_W-2:0]   r_addr;
    logic [3:0]          r_bmask;
    logic [31:0]         r_wdata;
    logic [15:0]         r_rd_lo;
    logic                r_cap_lo, r_cap_hi;

    logic                w_grant, w_gnt_port, w_sel_we;
    logic [3:0]          w_sel_bmask;
    logic                w_phase_last, w_in_phase, w_is_hi;
    logic                w_unused;

    assign w_unused = &{1'b0, i_p0_addr[31:ADDR_W+1], i_p0_addr[1:0],
                        i_p1_addr[31:ADDR_W+1], i_p1_addr[1:0]};

    assign w_phase_last = (r_cnt == c_cnt_last);
    assign w_in_phase   = (r_state == S_LO) || (r_state == S_HI);
    assign w_is_hi      = (r_state == S_HI);

    // On a tie the port that was not granted last wins.
    always_comb begin
        w_grant    = (r_state == S_IDLE) && (i_p0_valid || i_p1_valid);
        w_gnt_port = (i_p0_valid && i_p1_valid) ? ~r_last_grant : ~i_p0_valid;
        w_sel_we    = w_gnt_port ? i_p1_we    : i_p0_we;
        w_sel_bmask = w_gnt_port ? i_p1_bmask : i_p0_bmask;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_cnt_next = '0;
                    if (!w_sel_we || (w_sel_bmask[1:0] != 2'b00))
                        w_state_next = S_LO;
                    else if (w_sel_bmask[3:2] != 2'b00)
                        w_state_next = S_HI;
                    else
                        w_state_next = S_RESP;
                end
            end
            S_LO: begin
                if (w_phase_last) begin
                    w_cnt_next   = '0;
                    w_state_next = (!r_we || (r_bmask[3:2] != 2'b00)) ? S_HI : S_RESP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_HI: begin
                if (w_phase_last) begin
                    w_cnt_next   = '0;
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_bmask      <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_grant) begin
                r_last_grant <= w_gnt_port;
                r_gnt        <= w_gnt_port;
                r_we         <= w_sel_we;
                r_bmask      <= w_sel_bmask;
                r_addr       <= w_gnt_port ? i_p1_addr[ADDR_W:2] : i_p0_addr[ADDR_W:2];
                r_wdata      <= w_gnt_port ? i_p1_wdata : i_p0_wdata;
            end
        end
    end

    // Pad strobes are a registered decode of the state, so they trail it by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_p0_ready   <= 1'b0;
            o_p1_ready   <= 1'b0;
            o_p0_rvalid  <= 1'b0;
            o_p1_rvalid  <= 1'b0;
            o_p0_rdata   <= '0;
            o_p1_rdata   <= '0;
            o_sram_addr  <= '0;
            o_sram_dq_o  <= '0;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            r_rd_lo      <= '0;
            r_cap_lo     <= 1'b0;
            r_cap_hi     <= 1'b0;
        end else begin
            o_p0_ready   <= w_grant && !w_gnt_port;
            o_p1_ready   <= w_grant &&  w_gnt_port;
            o_p0_rvalid  <= (r_state == S_RESP) && !r_gnt;
            o_p1_rvalid  <= (r_state == S_RESP) &&  r_gnt;
            o_sram_ce_n  <= !w_in_phase;
            o_sram_oe_n  <= !(w_in_phase && !r_we);
            o_sram_we_n  <= !(w_in_phase && r_we && !w_phase_last);
            o_sram_dq_oe <= w_in_phase && r_we;
            if (w_in_phase) begin
                o_sram_addr <= {r_addr, w_is_hi};
                if (r_we) begin
                    o_sram_dq_o <= w_is_hi ? r_wdata[31:16] : r_wdata[15:0];
                    o_sram_lb_n <= ~(w_is_hi ? r_bmask[2] : r_bmask[0]);
                    o_sram_ub_n <= ~(w_is_hi ? r_bmask[3] : r_bmask[1]);
                end else begin
                    o_sram_lb_n <= 1'b0;
                    o_sram_ub_n <= 1'b0;
                end
            end else begin
                o_sram_lb_n <= 1'b1;
                o_sram_ub_n <= 1'b1;
            end
            r_cap_lo <= (r_state == S_LO) && w_phase_last && !r_we;
            r_cap_hi <= (r_state == S_HI) && w_phase_last && !r_we;
            if (r_cap_lo)
                r_rd_lo <= i_sram_dq_i;
            if (r_cap_hi) begin
                if (r_gnt)
                    o_p1_rdata <= {i_sram_dq_i, r_rd_lo};
                else
                    o_p0_rdata <= {i_sram_dq_i, r_rd_lo};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
- Shares the board's single external 16-bit asynchronous SRAM (256K x 16) between two 32-bit requesters in the non_forwarding core: port 0 is the load/store unit and port 1 is instruction fetch.
- Arbitrates between the two ports round-robin.
- Splits every 32-bit word access into low and high halfword SRAM phases, each with programmable wait states.
- Sits between the core and the FPGA top-level; the tri-state pad for the SRAM data bus is built in the top-level from the split data signals below.

Parameters:
- WAIT_CYCLES, 2: cycles per halfword phase. Must be >= 2.
- ADDR_W, 18: SRAM halfword address width.

Ports:
- i_clk  in  1: system clock.
- i_rst  in  1: synchronous reset, active-high.
- i_p0_valid  in  1: port 0 (LSU) request valid. Held with all request fields until o_p0_ready.
- i_p0_we  in  1: port 0 write (1) or read (0).
- i_p0_addr  in  32: port 0 byte address. Bits [1:0] are ignored.
- i_p0_bmask  in  4: port 0 byte-enable mask for writes.
- i_p0_wdata  in  32: port 0 write data.
- o_p0_ready  out  1: one-cycle pulse; request accepted.
- o_p0_rvalid  out  1: one-cycle pulse; transaction complete (reads and writes).
- o_p0_rdata  out  32: read data, valid while o_p0_rvalid is high.
- i_p1_valid, i_p1_we, i_p1_addr, i_p1_bmask, i_p1_wdata, o_p1_ready, o_p1_rvalid, o_p1_rdata: same widths and meanings, for port 1 (IF).
- o_sram_addr  out  ADDR_W: SRAM halfword address.
- o_sram_dq_o  out  16: write data toward the pad.
- o_sram_dq_oe  out  1: pad output enable.
- i_sram_dq_i  in  16: read data from the pad.
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each: SRAM strobes, active-low.

Behaviour:
- All outputs are registered.
- Reset values:
  - every SRAM strobe = 1;
  - o_sram_dq_oe = 0;
  - o_sram_addr = 0; o_sram_dq_o = 0;
  - all ready and rvalid outputs = 0; rdata = 0;
  - FSM = IDLE; last-grant pointer = port 1, so port 0 wins the first tie.
- Reset mid-transaction: the in-flight access is dropped, no rvalid is issued, and strobes are deasserted at the next edge.
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - If only one port is valid, grant it.
  - If both are valid, grant the port not granted last. The pointer updates on every grant.
  - On grant: pulse that port's ready, latch we/addr/bmask/wdata, go to LO.
  - If neither port is valid, stay in IDLE.
- LO and HI phases:
  - Each lasts exactly WAIT_CYCLES cycles.
  - o_sram_addr = {addr[ADDR_W:2], 0} in LO and {addr[ADDR_W:2], 1} in HI. Byte-address bits above ADDR_W are ignored (aliasing).
  - CE_N = 0 for the whole phase.
- Reads:
  - OE_N = 0, WE_N = 1, dq_oe = 0, LB_N = UB_N = 0.
  - i_sram_dq_i is captured on the last cycle of the phase: LO fills rdata[15:0], HI fills rdata[31:16].
  - Reads always run both phases and ignore bmask.
- Writes:
  - OE_N = 1 and dq_oe = 1 for the whole phase.
  - dq_o = wdata[15:0] in LO and wdata[31:16] in HI.
  - LB_N/UB_N = ~bmask[0]/~bmask[1] in LO and ~bmask[2]/~bmask[3] in HI.
  - WE_N = 0 for the first WAIT_CYCLES-1 cycles and 1 on the final cycle, so data is held past the WE rising edge.
  - LO is skipped if bmask[1:0] == 0. HI is skipped if bmask[3:2] == 0.
  - bmask == 0: go straight to RESP with no SRAM cycle.
- RESP:
  - Lasts one cycle: pulse the granted port's rvalid (with rdata for reads), then return to IDLE.
  - The next grant can happen in the cycle after RESP.
- Latency from ready to rvalid:
  - full read or full write = 2*WAIT_CYCLES + 1 cycles (5 at the default);
  - single-half write = WAIT_CYCLES + 1 cycles;
  - zero-mask write = 1 cycle.
- A request whose valid drops before ready is simply not served. Valid arriving during a busy transaction waits in IDLE arbitration.
- Only one transaction is outstanding at a time. rvalid never overlaps with ready for the same port.

Test Plan:
- Reset, then a port-0 read at 0x0000_0010 with the SRAM model holding halfword 8 = 0xBEEF and halfword 9 = 0xCAFE -> o_sram_addr 8 then 9; o_p0_rvalid arrives 5 cycles after ready with o_p0_rdata = 0xCAFEBEEF.
- Port-1 write at 0x20, wdata 0x12345678, bmask 4'b1111 -> halfword 16 = 0x5678 and halfword 17 = 0x1234. WE_N is low for 1 cycle per phase, and dq_oe is high only during LO and HI.
- Port-0 write, bmask 4'b0100, wdata 0x00AB0000 -> LO is skipped; only HI runs, with LB_N = 0 and UB_N = 1; rvalid arrives 3 cycles after ready. A bmask 0 write gives rvalid 1 cycle after ready and CE_N never asserts.
- Both ports valid continuously from reset -> grants go p0, p1, p0, p1; each ready pulse is for exactly one port.
- Assert i_rst during the HI phase of a read -> all strobes = 1 and dq_oe = 0 the next cycle, no rvalid, and a following port-1 read completes normally.
- Address 0x0008_0010 (above the SRAM range) -> aliases to halfword 8, same data as the first scenario.
